// File: rtl/div_request_sequencer.sv
// -----------------------------------------------------------------------------
// div_request_sequencer
//
// Wraps a multi-cycle divider. Signed operand pairs (plus a user tag) arrive
// on a valid/ready stream and are buffered in a DEPTH-entry FIFO. The sequencer
// issues one start pulse per request, waits for the divider's done pulse (or a
// watchdog expiry), and presents the result with its tag on a valid/ready
// output stream. Only one request is in flight at a time, so results leave in
// request order.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holds valid and its payload
// stable until that edge. Valid never depends on ready.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    request stream; in_a, in_b signed operands, in_tag
//   div_start/div_valid  one-cycle start pulse to the divider (same signal)
//   div_a/div_b          operands to the divider (FIFO head during issue)
//   div_q/div_r          divider results
//   div_done/div_err0    divider completion pulse and divide-by-zero flag
//   out_valid/out_ready  result stream; out_q, out_r, out_tag, out_div0,
//                        out_timeout (watchdog fired, q=r=0)
//   fifo_count           occupied FIFO entries
//   busy                 FSM not idle or FIFO not empty
//   fsm_state            current FSM state (debug observation)
// -----------------------------------------------------------------------------
module div_request_sequencer #(
  parameter int N       = 16,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_a,
  input  logic [N-1:0]               in_b,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       div_start,
  output logic                       div_valid,
  output logic [N-1:0]               div_a,
  output logic [N-1:0]               div_b,
  input  logic [N-1:0]               div_q,
  input  logic [N-1:0]               div_r,
  input  logic                       div_done,
  input  logic                       div_err0,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_q,
  output logic [N-1:0]               out_r,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_div0,
  output logic                       out_timeout,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       busy,
  output logic [1:0]                 fsm_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [N-1:0]     mem_a   [DEPTH];
  logic [N-1:0]     mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WD_W-1:0]  wd;

  logic push;
  logic pop;
  logic wd_expired;

  assign in_ready   = (count < CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1));
  // The head entry stays in the FIFO while it is in flight and is only
  // removed once its result (real or forced) has been captured.
  assign pop        = (state == S_WAIT) && (div_done || wd_expired);

  assign div_start  = (state == S_ISSUE);
  assign div_valid  = div_start;
  // Operands are only driven during the issue cycle so that the divider port
  // reads zero in every other state, including straight out of reset.
  assign div_a      = div_start ? mem_a[rd_ptr] : '0;
  assign div_b      = div_start ? mem_b[rd_ptr] : '0;

  assign out_valid  = (state == S_HOLD);
  assign fifo_count = count;
  assign busy       = (state != S_IDLE) || (count != '0);
  assign fsm_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count != '0) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (pop) state_nxt = S_HOLD;
      S_HOLD: begin
        // A push landing in the same cycle as the result handshake counts as
        // work still to do.
        if (out_ready) state_nxt = ((count != '0) || push) ? S_ISSUE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO storage has no reset: its contents are only read behind a non-zero
  // count, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Watchdog counts cycles spent in S_WAIT; reaching TIMEOUT-1 in S_WAIT
  // means this is the TIMEOUT-th waiting cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (state == S_ISSUE) begin
      wd <= '0;
    end else if (state == S_WAIT) begin
      wd <= wd + 1'b1;
    end
  end

  // Result capture. div_done takes priority over an expiry in the same cycle;
  // a done pulse in any other state is ignored because pop is gated by S_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_r       <= '0;
      out_tag     <= '0;
      out_div0    <= 1'b0;
      out_timeout <= 1'b0;
    end else if (pop) begin
      out_tag <= mem_tag[rd_ptr];
      if (div_done) begin
        out_q       <= div_q;
        out_r       <= div_r;
        out_div0    <= div_err0;
        out_timeout <= 1'b0;
      end else begin
        out_q       <= '0;
        out_r       <= '0;
        out_div0    <= 1'b0;
        out_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_request_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_request_sequencer
//
// Directed bench for div_request_sequencer. A small behavioural divider answers
// each start pulse three cycles later; it can be switched off to exercise the
// watchdog and reset-in-flight cases. Expected results are hand-computed.
// -----------------------------------------------------------------------------
module tb_div_request_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        div_start;
  logic        div_valid;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic [15:0] div_q;
  logic [15:0] div_r;
  logic        div_done;
  logic        div_err0;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic [15:0] out_r;
  logic [3:0]  out_tag;
  logic        out_div0;
  logic        out_timeout;
  logic [2:0]  fifo_count;
  logic        busy;
  logic [1:0]  fsm_state;

  int   checks;
  int   errors;
  int   start_cnt;
  logic resp_en;

  div_request_sequencer #(
    .N(16), .TAG_W(4), .DEPTH(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_start(div_start), .div_valid(div_valid),
    .div_a(div_a), .div_b(div_b),
    .div_q(div_q), .div_r(div_r),
    .div_done(div_done), .div_err0(div_err0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_tag(out_tag),
    .out_div0(out_div0), .out_timeout(out_timeout),
    .fifo_count(fifo_count), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / global time bound ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time bound reached");
  end

  // ---------------- behavioural divider ----------------
  initial begin : divider_model
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    div_done  = 1'b0;
    div_q     = '0;
    div_r     = '0;
    div_err0  = 1'b0;
    start_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (div_start) start_cnt++;
      if (resp_en && div_start) begin
        sa = div_a;
        sb = div_b;
        repeat (3) @(posedge clk);
        #2;
        if (sb == 16'sd0) begin
          div_q    = '0;
          div_r    = sa;
          div_err0 = 1'b1;
        end else begin
          div_q    = sa / sb;
          div_r    = sa % sb;
          div_err0 = 1'b0;
        end
        div_done = 1'b1;
        @(posedge clk);
        #2;
        div_done = 1'b0;
        div_err0 = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    waited   = 0;
    while (!in_ready && waited < 300) begin
      tick();
      waited++;
    end
    chk("push_accept", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic take_result(input string name, input logic [15:0] q, input logic [15:0] r,
                             input logic [3:0] t, input logic d0, input logic to);
    int waited;
    waited = 0;
    while (!out_valid && waited < 300) begin
      tick();
      waited++;
    end
    chk({name, "_valid"},   16'(out_valid), 16'd1);
    chk({name, "_q"},       out_q, q);
    chk({name, "_r"},       out_r, r);
    chk({name, "_tag"},     16'(out_tag), 16'(t));
    chk({name, "_div0"},    16'(out_div0), 16'(d0));
    chk({name, "_timeout"}, 16'(out_timeout), 16'(to));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_drop"},    16'(out_valid), 16'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    resp_en   = 1'b1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_in_ready",  16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_count",     16'(fifo_count), 16'd0);
    chk("rst_busy",      16'(busy), 16'd0);
    chk("rst_start",     16'(div_start), 16'd0);
    chk("rst_div_a",     div_a, 16'd0);
    rst_n = 1'b1;
    tick();

    // 1: 100/7 tag 3, start latency and operands
    push(16'd100, 16'd7, 4'd3);
    chk("t1_start_early", 16'(div_start), 16'd0);
    tick();
    chk("t1_start",  16'(div_start), 16'd1);
    chk("t1_valid",  16'(div_valid), 16'd1);
    chk("t1_div_a",  div_a, 16'd100);
    chk("t1_div_b",  div_b, 16'd7);
    tick();
    chk("t1_start_pulse", 16'(div_start), 16'd0);
    take_result("t1", 16'd14, 16'd2, 4'd3, 1'b0, 1'b0);
    chk("t1_start_cnt", 16'(start_cnt), 16'd1);

    // 2: signed cases back-to-back, order and tags preserved
    push(16'(-100), 16'd7, 4'd5);
    push(16'd100, 16'(-7), 4'd6);
    take_result("t2a", 16'(-14), 16'(-2), 4'd5, 1'b0, 1'b0);
    take_result("t2b", 16'(-14), 16'd2,   4'd6, 1'b0, 1'b0);

    // 3: divide by zero then a normal request
    push(16'd55, 16'd0, 4'd7);
    push(16'd9, 16'd3, 4'd8);
    take_result("t3a", 16'd0, 16'd55, 4'd7, 1'b1, 1'b0);
    take_result("t3b", 16'd3, 16'd0,  4'd8, 1'b0, 1'b0);

    // 4: fill the FIFO with out_ready low
    push(16'd10, 16'd3, 4'd0);
    push(16'(-9), 16'd2, 4'd1);
    push(16'd7, 16'd7, 4'd2);
    push(16'd0, 16'd5, 4'd3);
    chk("t4_full_count", 16'(fifo_count), 16'd4);
    chk("t4_full_ready", 16'(in_ready), 16'd0);
    in_valid = 1'b1;
    in_a     = 16'd32767;
    in_b     = 16'(-1);
    in_tag   = 4'd4;
    tick();
    chk("t4_fifth_blocked", 16'(fifo_count), 16'd4);
    in_valid = 1'b0;
    push(16'd32767, 16'(-1), 4'd4);
    chk("t4_refill_count", 16'(fifo_count), 16'd4);
    take_result("t4a", 16'd3,      16'd1,    4'd0, 1'b0, 1'b0);
    take_result("t4b", 16'(-4),    16'(-1),  4'd1, 1'b0, 1'b0);
    take_result("t4c", 16'd1,      16'd0,    4'd2, 1'b0, 1'b0);
    take_result("t4d", 16'd0,      16'd0,    4'd3, 1'b0, 1'b0);
    take_result("t4e", 16'(-32767), 16'd0,   4'd4, 1'b0, 1'b0);
    tick();
    chk("t4_idle_busy", 16'(busy), 16'd0);

    // 5: watchdog with no done, then a stale done in S_HOLD
    resp_en = 1'b0;
    push(16'd20, 16'd4, 4'd9);
    for (int i = 0; i < 10; i++) begin
      if (div_start) break;
      tick();
    end
    chk("t5_start", 16'(div_start), 16'd1);
    tick();
    repeat (63) tick();
    chk("t5_not_yet", 16'(out_valid), 16'd0);
    tick();
    chk("t5_valid",   16'(out_valid), 16'd1);
    chk("t5_timeout", 16'(out_timeout), 16'd1);
    chk("t5_q",       out_q, 16'd0);
    chk("t5_r",       out_r, 16'd0);
    chk("t5_div0",    16'(out_div0), 16'd0);
    chk("t5_tag",     16'(out_tag), 16'd9);
    div_q    = 16'd5;
    div_r    = 16'd1;
    div_err0 = 1'b1;
    div_done = 1'b1;
    tick();
    div_done = 1'b0;
    div_err0 = 1'b0;
    chk("t5_late_valid",   16'(out_valid), 16'd1);
    chk("t5_late_q",       out_q, 16'd0);
    chk("t5_late_timeout", 16'(out_timeout), 16'd1);
    chk("t5_late_div0",    16'(out_div0), 16'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5_drop", 16'(out_valid), 16'd0);
    chk("t5_busy", 16'(busy), 16'd0);

    // 6: reset while waiting with three entries queued
    push(16'd20, 16'd4, 4'd1);
    push(16'd21, 16'd4, 4'd2);
    push(16'd22, 16'd4, 4'd3);
    tick();
    tick();
    chk("t6_pre_count", 16'(fifo_count), 16'd3);
    chk("t6_pre_busy",  16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_count",     16'(fifo_count), 16'd0);
    chk("t6_out_valid", 16'(out_valid), 16'd0);
    chk("t6_in_ready",  16'(in_ready), 16'd1);
    chk("t6_start",     16'(div_start), 16'd0);
    chk("t6_busy",      16'(busy), 16'd0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("t6_post_start", 16'(div_start), 16'd0);
    chk("t6_post_count", 16'(fifo_count), 16'd0);

    // recovery after reset
    resp_en = 1'b1;
    push(16'(-7), 16'd2, 4'd15);
    take_result("t6r", 16'(-3), 16'(-1), 4'd15, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
